// File: rtl/pc_fetch_ctrl_if.sv
// Fetch/execute handshake bundle between the PC fetch controller and its environment.
// The master side is the controller; the slave side is imem plus the datapath.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        exec_done;
  logic [31:0] next_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
           halted, fault, fault_code, retired,
    input  imem_ack, imem_rdata, exec_done, next_pc, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
           halted, fault, fault_code, retired,
    output imem_ack, imem_rdata, exec_done, next_pc, halt_req
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: fetches one instruction, holds it for execution, advances the PC,
// and stops permanently on halt request, fetch timeout or a misaligned next PC.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [3:0] TMO_MAX      = 4'(FETCH_TIMEOUT);
  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_ALIGN   = 2'b10;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [3:0]  tmo_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic        fault_q;
  logic [1:0]  fault_code_q;

  // State machine, datapath registers and registered status outputs in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pc_out_q     <= RESET_PC;
      instr_q      <= 32'h0000_0000;
      retired_q    <= 32'h0000_0000;
      tmo_q        <= 4'd0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          // An ack on the last allowed cycle still completes the fetch.
          if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc_q;
            tmo_q    <= 4'd0;
            state_q  <= ST_EXEC;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
          end else if (tmo_q == TMO_MAX) begin
            state_q      <= ST_ERR;
            req_q        <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= CODE_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + 4'd1;
          end
        end
        ST_EXEC: begin
          if (bus.exec_done) begin
            valid_q <= 1'b0;
            if (bus.next_pc[1:0] != 2'b00) begin
              state_q      <= ST_ERR;
              fault_q      <= 1'b1;
              fault_code_q <= CODE_ALIGN;
            end else begin
              pc_q      <= bus.next_pc;
              retired_q <= retired_q + 32'd1;
              if (bus.halt_req) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end else begin
                state_q <= ST_FETCH;
                req_q   <= 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          // Unreachable encoding: park in the error state with outputs quiesced.
          state_q      <= ST_ERR;
          req_q        <= 1'b0;
          valid_q      <= 1'b0;
          fault_q      <= 1'b1;
          fault_code_q <= CODE_NONE;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, fetch/execute, timeout, misalignment, halt, reset override.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   checks_r;
  int   errors_r;
  int   cyc_r;
  int   fetch_at_r;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_r++;
  endtask

  task automatic idle_inputs();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0000_0000;
    bus.exec_done  = 1'b0;
    bus.next_pc    = 32'h0000_0000;
    bus.halt_req   = 1'b0;
  endtask

  // Leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic fetch(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic retire(input logic [31:0] npc, input logic hlt);
    bus.exec_done = 1'b1;
    bus.next_pc   = npc;
    bus.halt_req  = hlt;
    step();
    bus.exec_done = 1'b0;
    bus.halt_req  = 1'b0;
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    cyc_r    = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();

    // Reset state.
    chk("rst_req",   32'(bus.imem_req),    32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr",  bus.imem_addr,        32'h0000_3000);
    chk("rst_pcout", bus.pc_out,           32'h0000_3000);
    chk("rst_instr", bus.instr,            32'h0000_0000);
    chk("rst_ret",   bus.retired,          32'd0);
    chk("rst_stat",  {29'd0, bus.halted, bus.fault_code}, 32'd0);
    chk("rst_fault", 32'(bus.fault),       32'd0);

    rst = 1'b0;
    step();
    chk("fetch_req",  32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr,     32'h0000_3000);
    fetch_at_r = cyc_r;

    // First fetch and execute.
    fetch(32'h8C01_0004);
    chk("exec_valid", 32'(bus.instr_valid), 32'd1);
    chk("exec_instr", bus.instr,            32'h8C01_0004);
    chk("exec_pcout", bus.pc_out,           32'h0000_3000);
    chk("exec_req",   32'(bus.imem_req),    32'd0);
    step();
    chk("exec_hold",  bus.instr,            32'h8C01_0004);
    retire(32'h0000_3004, 1'b0);
    chk("ret1_cnt",   bus.retired,          32'd1);
    chk("ret1_addr",  bus.imem_addr,        32'h0000_3004);
    chk("ret1_req",   32'(bus.imem_req),    32'd1);
    chk("ret1_valid", 32'(bus.instr_valid), 32'd0);
    chk("latency",    32'(cyc_r - fetch_at_r), 32'd3);

    // exec_done and halt_req are ignored while fetching.
    bus.exec_done = 1'b1;
    bus.next_pc   = 32'h0000_3008;
    bus.halt_req  = 1'b1;
    step();
    idle_inputs();
    chk("ign_done_addr", bus.imem_addr, 32'h0000_3004);
    chk("ign_done_ret",  bus.retired,   32'd1);
    bus.halt_req = 1'b1;
    fetch(32'h0000_0013);
    bus.halt_req = 1'b0;
    chk("ign_halt_valid",  32'(bus.instr_valid), 32'd1);
    chk("ign_halt_halted", 32'(bus.halted),      32'd0);
    chk("ign_halt_pcout",  bus.pc_out,           32'h0000_3004);
    retire(32'h0000_3008, 1'b0);
    chk("ret2_addr", bus.imem_addr, 32'h0000_3008);

    // Ack on the 16th un-acknowledged cycle wins over the timeout.
    for (int i = 0; i < 15; i++) step();
    chk("tmo15_req",   32'(bus.imem_req), 32'd1);
    chk("tmo15_fault", 32'(bus.fault),    32'd0);
    fetch(32'h1234_5678);
    chk("tmo_ack_fault", 32'(bus.fault),       32'd0);
    chk("tmo_ack_valid", 32'(bus.instr_valid), 32'd1);
    chk("tmo_ack_instr", bus.instr,            32'h1234_5678);
    retire(32'h0000_300C, 1'b0);
    chk("ret3_cnt", bus.retired, 32'd3);

    // Halt on retire; later pulses change nothing.
    fetch(32'hAAAA_5555);
    retire(32'h0000_3010, 1'b1);
    chk("halt_halted", 32'(bus.halted),   32'd1);
    chk("halt_ret",    bus.retired,       32'd4);
    chk("halt_req",    32'(bus.imem_req), 32'd0);
    bus.imem_ack  = 1'b1;
    bus.exec_done = 1'b1;
    bus.next_pc   = 32'h0000_4000;
    step();
    step();
    idle_inputs();
    chk("halt_stay",   32'(bus.halted),      32'd1);
    chk("halt_ret2",   bus.retired,          32'd4);
    chk("halt_addr",   bus.imem_addr,        32'h0000_3010);
    chk("halt_valid",  32'(bus.instr_valid), 32'd0);

    // Misaligned next_pc from a fresh reset.
    do_reset();
    chk("rst_halt_clr", 32'(bus.halted), 32'd0);
    fetch(32'h8C01_0004);
    retire(32'h0000_3006, 1'b0);
    chk("mis_fault", 32'(bus.fault),      32'd1);
    chk("mis_code",  32'(bus.fault_code), 32'd2);
    chk("mis_addr",  bus.imem_addr,       32'h0000_3000);
    chk("mis_ret",   bus.retired,         32'd0);
    chk("mis_valid", 32'(bus.instr_valid), 32'd0);

    // Full fetch timeout: 16 cycles without ack.
    do_reset();
    for (int i = 0; i < 15; i++) step();
    chk("to_pre_fault", 32'(bus.fault), 32'd0);
    step();
    chk("to_fault", 32'(bus.fault),      32'd1);
    chk("to_code",  32'(bus.fault_code), 32'd1);
    chk("to_req",   32'(bus.imem_req),   32'd0);
    fetch(32'hDEAD_BEEF);
    chk("to_ign_valid", 32'(bus.instr_valid), 32'd0);
    chk("to_ign_code",  32'(bus.fault_code),  32'd1);

    // Reset in EXEC with retired=5, pending exec_done discarded.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(32'h0000_0013);
      retire(32'h0000_3004 + 32'(i) * 32'd4, 1'b0);
    end
    chk("five_ret",  bus.retired,   32'd5);
    chk("five_addr", bus.imem_addr, 32'h0000_3014);
    fetch(32'h0000_0013);
    bus.exec_done = 1'b1;
    bus.next_pc   = 32'h0000_3018;
    rst = 1'b1;
    step();
    idle_inputs();
    chk("rexec_ret",   bus.retired,          32'd0);
    chk("rexec_addr",  bus.imem_addr,        32'h0000_3000);
    chk("rexec_valid", 32'(bus.instr_valid), 32'd0);
    chk("rexec_req",   32'(bus.imem_req),    32'd0);
    chk("rexec_instr", bus.instr,            32'h0000_0000);
    rst = 1'b0;
    step();
    chk("rexec_fetch", 32'(bus.imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
